ram_sync: RTL and testbench

//  Parametrised dual-port data RAM with registered (1-cycle) reads, byte-masked writes,

---
 rtl/ram_sync.sv | 81 ++++++++
 tb/tb_ram_sync.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ram_sync.sv
// ram_sync: dual-port RAM, registered reads, byte-masked write-first port 2, range check, post-reset zero-fill
module ram_sync #(
  parameter int WORD_CNT       = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    re1,
  input  logic [ADDR_WIDTH-1:0]   a1,
  output logic [DATA_WIDTH-1:0]   do1,
  output logic                    dv1,
  output logic                    err1,
  input  logic                    re2,
  input  logic                    we2,
  input  logic [ADDR_WIDTH-1:0]   a2,
  input  logic [DATA_WIDTH-1:0]   di2,
  input  logic [DATA_WIDTH/8-1:0] m2,
  output logic [DATA_WIDTH-1:0]   do2,
  output logic                    dv2,
  output logic                    err2,
  output logic                    busy
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int SH = $clog2(NB);
  localparam int IW = (WORD_CNT > 1) ? $clog2(WORD_CNT) : 1;
  typedef enum logic {CLEAR, READY} state_t;
  state_t state;
  logic [IW-1:0] ptr;
  logic [DATA_WIDTH-1:0] mem [WORD_CNT];
  logic [ADDR_WIDTH-1:0] idx1, idx2;
  logic [DATA_WIDTH-1:0] bm, merged, rd1, rd2;
  logic in1, in2, wr;
  assign busy = state == CLEAR;
  assign idx1 = a1 >> SH;
  assign idx2 = a2 >> SH;
  assign in1  = idx1 < ADDR_WIDTH'(WORD_CNT);
  assign in2  = idx2 < ADDR_WIDTH'(WORD_CNT);
  assign wr   = !busy && we2 && in2;
  // Merged word for port 2's write; both read ports see it on a same-word collision
  always_comb begin
    bm = '0;
    for (int i = 0; i < NB; i++) bm[8*i +: 8] = {8{m2[i]}};
    merged = (mem[idx2[IW-1:0]] & ~bm) | (di2 & bm);
    rd1 = (wr && idx1 == idx2) ? merged : mem[idx1[IW-1:0]];
    rd2 = wr ? merged : mem[idx2[IW-1:0]];
  end
  // Storage: zero-fill one word per cycle while clearing, otherwise the masked port 2 write
  always_ff @(posedge clk) begin
    if (rst_n && busy) mem[ptr] <= '0;
    else if (rst_n && wr) mem[idx2[IW-1:0]] <= merged;
  end
  // Clear sequencer and registered read/valid/error outputs; requests are ignored while busy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR_ON_RESET ? CLEAR : READY;
      ptr   <= '0;
      do1   <= '0;
      do2   <= '0;
      dv1   <= 1'b0;
      dv2   <= 1'b0;
      err1  <= 1'b0;
      err2  <= 1'b0;
    end else if (busy) begin
      dv1  <= 1'b0;
      dv2  <= 1'b0;
      err1 <= 1'b0;
      err2 <= 1'b0;
      ptr  <= ptr + 1'b1;
      if (ptr == IW'(WORD_CNT - 1)) state <= READY;
    end else begin
      dv1  <= re1;
      err1 <= re1 && !in1;
      dv2  <= re2;
      err2 <= (re2 || we2) && !in2;
      if (re1) do1 <= in1 ? rd1 : '0;
      if (re2) do2 <= in2 ? rd2 : '0;
    end
  end
endmodule

// File: tb/tb_ram_sync.sv
// tb_ram_sync: randomized scoreboard bench for ram_sync plus a 64-bit no-clear instance
module tb_ram_sync;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic re1 = 1'b0, re2 = 1'b0, we2 = 1'b0;
  logic [31:0] a1 = '0, a2 = '0, di2 = '0;
  logic [3:0] m2 = '0;
  logic [31:0] do1, do2;
  logic dv1, dv2, err1, err2, busy;
  logic b_re1 = 1'b0, b_re2 = 1'b0, b_we2 = 1'b0;
  logic [31:0] b_a1 = '0, b_a2 = '0;
  logic [63:0] b_di2 = '0;
  logic [7:0] b_m2 = '0;
  logic [63:0] b_do1, b_do2;
  logic b_dv1, b_dv2, b_err1, b_err2, b_busy;
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] d; logic dv; logic err;} exp_t;
  exp_t q1[$], q2[$];
  logic [31:0] ref_mem [16];
  always #5 clk = ~clk;
  ram_sync dut (
    .clk(clk), .rst_n(rst_n), .re1(re1), .a1(a1), .do1(do1), .dv1(dv1), .err1(err1),
    .re2(re2), .we2(we2), .a2(a2), .di2(di2), .m2(m2), .do2(do2), .dv2(dv2), .err2(err2), .busy(busy)
  );
  ram_sync #(.WORD_CNT(8), .DATA_WIDTH(64), .ADDR_WIDTH(32), .CLEAR_ON_RESET(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .re1(b_re1), .a1(b_a1), .do1(b_do1), .dv1(b_dv1), .err1(b_err1),
    .re2(b_re2), .we2(b_we2), .a2(b_a2), .di2(b_di2), .m2(b_m2), .do2(b_do2), .dv2(b_dv2),
    .err2(b_err2), .busy(b_busy)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference: word array updated byte by byte; reads see the post-write word when addresses match
  task automatic op(input bit r1, input logic [31:0] x1, input bit r2, input bit w2,
                    input logic [31:0] x2, input logic [31:0] d, input logic [3:0] m);
    int i1, i2;
    bit wv;
    logic [31:0] mg;
    @(negedge clk);
    re1 = r1; a1 = x1; re2 = r2; we2 = w2; a2 = x2; di2 = d; m2 = m;
    if (busy) return;
    i1 = int'(x1 / 4);
    i2 = int'(x2 / 4);
    wv = w2 && i2 < 16;
    mg = (i2 < 16) ? ref_mem[i2] : 32'h0;
    for (int b = 0; b < 4; b++) if (m[b]) mg[8*b +: 8] = d[8*b +: 8];
    if (r1) q1.push_back('{(i1 >= 16) ? 32'h0 : (wv && i1 == i2) ? mg : ref_mem[i1], 1'b1, i1 >= 16});
    if (r2 || (w2 && i2 >= 16))
      q2.push_back('{!r2 ? 32'h0 : (i2 >= 16) ? 32'h0 : wv ? mg : ref_mem[i2], r2, i2 >= 16});
    if (wv) ref_mem[i2] = mg;
  endtask
  task automatic idle();
    op(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic wait_ready(input int hold, output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      re1 = (k < hold);
      @(posedge clk);
      #1;
      n++;
      if (!busy) break;
    end
    re1 = 1'b0;
  endtask
  // Monitor: every presented response must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (dv1 || err1) begin
      if (q1.size() == 0) chk("p1_unexpected_dv", {62'h0, dv1, err1}, 64'h0);
      else begin
        e = q1.pop_front();
        chk("p1_data", do1, e.d);
        chk("p1_err", err1, e.err);
        chk("p1_dv", dv1, 1);
      end
    end
    if (dv2 || err2) begin
      if (q2.size() == 0) chk("p2_unexpected", {62'h0, dv2, err2}, 64'h0);
      else begin
        e = q2.pop_front();
        if (e.dv) chk("p2_data", do2, e.d);
        chk("p2_err", err2, e.err);
        chk("p2_dv", dv2, e.dv);
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    logic [63:0] w [3];
    repeat (2) @(posedge clk);
    #1;
    chk("rst_do1", do1, 0);
    chk("rst_do2", do2, 0);
    chk("rst_dv", {dv1, dv2, err1, err2}, 0);
    chk("rst_busy", busy, 1);
    chk("b_rst_busy", b_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(0, n);
    chk("clear_cycles_first", n, 16);
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    for (int i = 0; i < 16; i++) op(0, 0, 0, 1, i * 4, 32'hFFFF_FFFF, 4'hF);
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    re1 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    chk("busy_after_mid_reset", busy, 1);
    wait_ready(3, n);
    chk("clear_cycles_restart", n, 16);
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    for (int i = 0; i < 16; i++) op(1, i * 4, 1, 0, (15 - i) * 4, 0, 0);
    op(0, 0, 0, 1, 8, 32'h1122_3344, 4'hF);
    op(0, 0, 0, 1, 8, 32'hAABB_CCDD, 4'b0101);
    op(1, 8, 0, 0, 0, 0, 0);
    op(1, 4, 1, 1, 4, 32'hCAFE_F00D, 4'hF);
    op(1, 32'h40, 0, 0, 0, 0, 0);
    op(0, 0, 0, 1, 32'h40, 32'hDEAD_BEEF, 4'hF);
    op(0, 0, 1, 1, 32'h44, 32'hDEAD_BEEF, 4'hF);
    op(0, 0, 0, 1, 12, 32'h1234_5678, 4'h0);
    for (int i = 0; i < 16; i++) op(1, i * 4, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      op($urandom_range(0, 1), $urandom_range(0, 'h4F), $urandom_range(0, 1), $urandom_range(0, 1),
         $urandom_range(0, 'h4F), $urandom, $urandom_range(0, 15));
    idle();
    idle();
    idle();
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    for (int i = 0; i < 3; i++) w[i] = {32'h0123_4567 + i, 32'h89AB_CDEF};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_we2 = 1'b1;
      b_a2 = (i < 3) ? i * 8 : 8;
      b_di2 = (i < 3) ? w[i] : 64'hFFFF_FFFF_FFFF_FFFF;
      b_m2 = (i < 3) ? 8'hFF : 8'h80;
    end
    @(negedge clk);
    b_a2 = 32'h10;
    b_di2 = '0;
    b_m2 = 8'h00;
    @(negedge clk);
    b_we2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_re1 = 1'b1;
      b_a1 = i * 8;
      @(negedge clk);
      b_re1 = 1'b0;
      chk("b_dv1", b_dv1, 1);
      chk("b_err1", b_err1, 0);
      chk("b_word", b_do1, (i == 1) ? {8'hFF, w[1][55:0]} : w[i]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
